// File: rtl/dut_capture_ctrl.sv
// dut_capture_ctrl: sequencer between the USB register block and the AES core (dut_clk domain).
// A rising edge on start produces a one-cycle core_load. The block then waits for core_busy,
// times the run, captures the ciphertext when busy falls, holds a scope trigger window for
// POST_CYCLES extra cycles and raises a sticky done flag. If the core never goes busy within
// TIMEOUT cycles, a sticky timeout flag is raised instead.
//
// Optional feature macro: DUT_CYCLE_COUNT_EN
//   defined   -> cycle_count counts the core_busy cycles of the last run (saturating)
//   undefined -> the counter is removed and cycle_count is tied to 0
//
// Ports:
//   clk         in   dut clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   start request (rising edge detected internally)
//   clear       in   synchronous clear of done/timeout
//   core_busy   in   AES core busy flag
//   core_data   in   AES core ciphertext [DATA_WIDTH]
//   core_load   out  one-cycle load pulse to the core
//   data_out    out  captured ciphertext [DATA_WIDTH]
//   done        out  sticky capture-complete flag
//   timeout     out  sticky core-never-started flag
//   busy        out  high whenever the FSM is not idle
//   trigger     out  scope trigger window
//   cycle_count out  core_busy cycles of the last run [CNT_WIDTH]

module dut_capture_ctrl #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned POST_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  core_busy,
  input  logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_load,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  timeout,
  output logic                  busy,
  output logic                  trigger,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PostW = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [PostW-1:0] PostLast = PostW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitBusy,
    StRun,
    StPost
  } state_e;

  state_e                  state_q, state_d;
  logic                    start_q;
  logic                    start_edge;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [PostW-1:0]        post_q, post_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    trigger_q, trigger_d;
  logic                    cnt_clr;
  logic                    cnt_inc;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    post_d    = post_q;
    data_d    = data_q;
    trigger_d = trigger_q;
    // Clear is applied first so that any set below overrides it.
    done_d    = clear ? 1'b0 : done_q;
    timeout_d = clear ? 1'b0 : timeout_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StLoad;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StLoad: begin
        wait_d  = '0;
        cnt_clr = 1'b1;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (core_busy) begin
          // The cycle that sees busy rise is counted as a busy cycle.
          state_d   = StRun;
          trigger_d = 1'b1;
          cnt_inc   = 1'b1;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRun: begin
        if (core_busy) begin
          cnt_inc = 1'b1;
        end else begin
          data_d = core_data;
          if (POST_CYCLES == 0) begin
            done_d    = 1'b1;
            trigger_d = 1'b0;
            state_d   = StIdle;
          end else begin
            post_d  = '0;
            state_d = StPost;
          end
        end
      end
      StPost: begin
        // core_busy is deliberately ignored here.
        if (post_q == PostLast) begin
          trigger_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          post_d = post_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      wait_q    <= '0;
      post_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      wait_q    <= wait_d;
      post_q    <= post_d;
      data_q    <= data_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      trigger_q <= trigger_d;
    end
  end

`ifdef DUT_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cycle_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt  = cnt_clr ^ cnt_inc;
  assign cycle_count = '0;
`endif

  // All outputs come straight from flops or from decoded state flops.
  assign core_load = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign data_out  = data_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign trigger   = trigger_q;

endmodule

// File: tb/tb_dut_capture_ctrl.sv
// Directed bench for dut_capture_ctrl. Two instances share all inputs: dut (POST_CYCLES=4)
// and dut0 (POST_CYCLES=0). Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, so sample i reflects the state after edge i of a run.
module tb_dut_capture_ctrl;

  localparam int DW = 128;
  localparam int CW = 16;
`ifdef DUT_CYCLE_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, clear, core_busy;
  logic [DW-1:0] core_data;

  logic          core_load, done, timeout, busy, trigger;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cycle_count;
  logic          core_load0, done0, timeout0, busy0, trigger0;
  logic [DW-1:0] data_out0;
  logic [CW-1:0] cycle_count0;

  int checks   = 0;
  int failures = 0;

  // Per-sample history of the last run.
  logic trig_h[0:299];
  logic load_h[0:299];
  logic done_h[0:299];
  logic busy_h[0:299];
  logic tmo_h[0:299];
  logic trig0_h[0:299];
  logic done0_h[0:299];
  int   load_cnt, load0_cnt, load_at;

  localparam logic [DW-1:0] D1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [DW-1:0] D2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] D3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [DW-1:0] D4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  dut_capture_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .POST_CYCLES(4),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .core_busy  (core_busy),
    .core_data  (core_data),
    .core_load  (core_load),
    .data_out   (data_out),
    .done       (done),
    .timeout    (timeout),
    .busy       (busy),
    .trigger    (trigger),
    .cycle_count(cycle_count)
  );

  dut_capture_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .POST_CYCLES(0),
    .TIMEOUT    (255)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .core_busy  (core_busy),
    .core_data  (core_data),
    .core_load  (core_load0),
    .data_out   (data_out0),
    .done       (done0),
    .timeout    (timeout0),
    .busy       (busy0),
    .trigger    (trigger0),
    .cycle_count(cycle_count0)
  );

  // Stimulus only: raises start before edge 1 and models the AES core, which holds busy for
  // busy_len cycles starting one cycle after the load pulse. clear is sampled at clear_edge,
  // an extra start pulse at repulse_edge (0 = never).
  task automatic drive_run(input int ncyc, input int hold_start, input int busy_len,
                           input int clear_edge, input int repulse_edge, input logic [DW-1:0] d);
    start     = 1'b1;
    core_data = d;
    load_cnt  = 0;
    load0_cnt = 0;
    load_at   = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      trig_h[i]  = trigger;
      load_h[i]  = core_load;
      done_h[i]  = done;
      busy_h[i]  = busy;
      tmo_h[i]   = timeout;
      trig0_h[i] = trigger0;
      done0_h[i] = done0;
      if (core_load) begin
        load_cnt++;
        if (load_at < 0) load_at = i;
      end
      if (core_load0) load0_cnt++;
      start     = (i < hold_start) || (i + 1 == repulse_edge);
      core_busy = (load_at >= 0) && (i >= load_at + 1) && (i <= load_at + busy_len);
      clear     = (i + 1 == clear_edge);
    end
    start     = 1'b0;
    core_busy = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({core_load, done, timeout, busy, trigger} !== 5'b0 || data_out !== '0 ||
        cycle_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got load/done/tmo/busy/trig=%b data=%h cnt=%0d required all 0",
               {core_load, done, timeout, busy, trigger}, data_out, cycle_count);
    end
    checks++;
    if ({core_load0, done0, timeout0, busy0, trigger0} !== 5'b0 || data_out0 !== '0) begin
      failures++;
      $display("FAIL reset_outputs_post0: got flags=%b data=%h required all 0",
               {core_load0, done0, timeout0, busy0, trigger0}, data_out0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_normal;
    int tcnt, tfirst, tlast;
    drive_run(25, 1, 10, 0, 0, D1);
    tcnt = 0; tfirst = -1; tlast = -1;
    for (int i = 1; i <= 25; i++) begin
      if (trig_h[i]) begin
        tcnt++;
        if (tfirst < 0) tfirst = i;
        tlast = i;
      end
    end
    checks++;
    if (load_cnt != 1 || load_at != 1) begin
      failures++;
      $display("FAIL normal_load: got count=%0d at=%0d required count=1 at=1", load_cnt, load_at);
    end
    checks++;
    if (tcnt != 14 || tfirst != 3 || tlast != 16) begin
      failures++;
      $display("FAIL normal_trigger: got len=%0d first=%0d last=%0d required 14/3/16",
               tcnt, tfirst, tlast);
    end
    checks++;
    if (done_h[16] !== 1'b0 || done_h[17] !== 1'b1) begin
      failures++;
      $display("FAIL normal_done: got done@16=%b done@17=%b required 0/1", done_h[16], done_h[17]);
    end
    checks++;
    if (busy_h[1] !== 1'b1 || busy_h[16] !== 1'b1 || busy_h[17] !== 1'b0) begin
      failures++;
      $display("FAIL normal_busy: got @1=%b @16=%b @17=%b required 1/1/0",
               busy_h[1], busy_h[16], busy_h[17]);
    end
    checks++;
    if (data_out !== D1) begin
      failures++;
      $display("FAIL normal_data: got %h required %h", data_out, D1);
    end
    checks++;
    if (cycle_count !== (CntEn ? 16'd10 : 16'd0)) begin
      failures++;
      $display("FAIL normal_cycle_count: got %0d required %0d", cycle_count, CntEn ? 10 : 0);
    end
  endtask

  task automatic test_timeout;
    int tcnt;
    drive_run(262, 1, 0, 0, 0, D2);
    tcnt = 0;
    for (int i = 1; i <= 262; i++) if (trig_h[i]) tcnt++;
    checks++;
    if (tmo_h[256] !== 1'b0 || tmo_h[257] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag: got @256=%b @257=%b required 0/1", tmo_h[256], tmo_h[257]);
    end
    checks++;
    if (busy_h[256] !== 1'b1 || busy_h[257] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got @256=%b @257=%b required 1/0", busy_h[256], busy_h[257]);
    end
    checks++;
    if (done !== 1'b0 || tcnt != 0 || data_out !== D1) begin
      failures++;
      $display("FAIL timeout_side: got done=%b trig_cycles=%0d data=%h required 0/0/%h",
               done, tcnt, data_out, D1);
    end
  endtask

  task automatic test_held_start;
    drive_run(90, 50, 60, 0, 55, D2);
    checks++;
    if (load_cnt != 1 || load0_cnt != 1) begin
      failures++;
      $display("FAIL held_start_loads: got %0d/%0d required 1/1", load_cnt, load0_cnt);
    end
    checks++;
    if (done_h[67] !== 1'b1 || done_h[66] !== 1'b0 || tmo_h[2] !== 1'b0) begin
      failures++;
      $display("FAIL held_start_done: got @66=%b @67=%b tmo@2=%b required 0/1/0",
               done_h[66], done_h[67], tmo_h[2]);
    end
    checks++;
    if (data_out !== D2 || cycle_count !== (CntEn ? 16'd60 : 16'd0)) begin
      failures++;
      $display("FAIL held_start_capture: got data=%h cnt=%0d required %h/%0d",
               data_out, cycle_count, D2, CntEn ? 60 : 0);
    end
  endtask

  task automatic test_clear;
    drive_run(20, 1, 10, 17, 0, D3);
    checks++;
    if (done_h[16] !== 1'b0 || done_h[17] !== 1'b1 || done_h[18] !== 1'b1) begin
      failures++;
      $display("FAIL clear_same_cycle: got @16=%b @17=%b @18=%b required 0/1/1",
               done_h[16], done_h[17], done_h[18]);
    end
    drive_run(20, 1, 10, 18, 0, D3);
    checks++;
    if (done_h[17] !== 1'b1 || done_h[18] !== 1'b0) begin
      failures++;
      $display("FAIL clear_next_cycle: got @17=%b @18=%b required 1/0", done_h[17], done_h[18]);
    end
  endtask

  task automatic test_reset_mid_run;
    drive_run(8, 1, 10, 0, 0, D4);
    checks++;
    if (trig_h[8] !== 1'b1 || busy_h[8] !== 1'b1) begin
      failures++;
      $display("FAIL midrun_precond: got trig=%b busy=%b required 1/1", trig_h[8], busy_h[8]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trigger, busy, core_load, done} !== 4'b0 || data_out !== '0 || cycle_count !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got trig/busy/load/done=%b data=%h cnt=%0d required 0",
               {trigger, busy, core_load, done}, data_out, cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_run(20, 1, 10, 0, 0, D4);
    checks++;
    if (load_cnt != 1 || done_h[17] !== 1'b1 || data_out !== D4) begin
      failures++;
      $display("FAIL midrun_restart: got loads=%0d done@17=%b data=%h required 1/1/%h",
               load_cnt, done_h[17], data_out, D4);
    end
  endtask

  task automatic test_post0;
    drive_run(20, 1, 10, 0, 0, D1);
    checks++;
    if (trig0_h[3] !== 1'b1 || trig0_h[12] !== 1'b1 || trig0_h[13] !== 1'b0 ||
        trig0_h[2] !== 1'b0) begin
      failures++;
      $display("FAIL post0_trigger: got @2=%b @3=%b @12=%b @13=%b required 0/1/1/0",
               trig0_h[2], trig0_h[3], trig0_h[12], trig0_h[13]);
    end
    checks++;
    if (done0_h[12] !== 1'b0 || done0_h[13] !== 1'b1) begin
      failures++;
      $display("FAIL post0_done: got @12=%b @13=%b required 0/1", done0_h[12], done0_h[13]);
    end
    checks++;
    if (data_out0 !== D1 || cycle_count0 !== (CntEn ? 16'd10 : 16'd0) || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL post0_capture: got data=%h cnt=%0d busy=%b required %h/%0d/0",
               data_out0, cycle_count0, busy0, D1, CntEn ? 10 : 0);
    end
  endtask

  initial begin
    start     = 1'b0;
    clear     = 1'b0;
    core_busy = 1'b0;
    core_data = '0;
    test_reset();
    test_normal();
    test_timeout();
    test_held_start();
    test_clear();
    test_reset_mid_run();
    test_post0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
